// File: rtl/autoconfig_multi.sv
`default_nettype none
// ============================================================================
// Module   : autoconfig_multi
// Brief    : Zorro AUTOCONFIG responder presenting several logical boards in turn.
// Revision : 1.0
// ============================================================================
module autoconfig_multi #(
    parameter int                      NUM_BOARDS = 2,
    parameter bit                      ZORRO3     = 1'b1,
    parameter logic [15:0]             MFG_ID     = 16'd5194,
    parameter logic [7:0]              PROD_ID    = 8'h03,
    parameter logic [31:0]             SERIAL     = 32'd0,
    parameter logic [4*NUM_BOARDS-1:0] BOARD_SIZE = {4'b0100, 4'b0100}
) (
    input  logic                      CLK,
    input  logic                      RESET_n,
    input  logic                      FCS_n,
    input  logic                      autoconfig_cycle,
    input  logic [1:0]                z3_state,
    input  logic [6:0]                ADDRL,
    input  logic                      READ,
    input  logic [3:0]                DIN,
    output logic [3:0]                DOUT,
    output logic                      dtack,
    output logic                      CFGOUT_n,
    output logic [1:0]                cur_board,
    output logic                      all_done,
    output logic [NUM_BOARDS-1:0]     configured,
    output logic [NUM_BOARDS-1:0]     shutup,
    output logic [8*NUM_BOARDS-1:0]   base_addr
);

    localparam logic [1:0] c_Z3_DATA    = 2'b11;
    localparam logic [1:0] c_LAST_BOARD = 2'(NUM_BOARDS - 1);

    logic [3:0]              r_dout;
    logic                    r_dtack;
    logic                    r_cfgout_n;
    logic [1:0]              r_cur_board;
    logic                    r_all_done;
    logic [NUM_BOARDS-1:0]   r_configured;
    logic [NUM_BOARDS-1:0]   r_shutup;
    logic [8*NUM_BOARDS-1:0] r_base_addr;
    logic [3:0]              r_pending;
    logic                    r_fired;
    logic                    r_fcs_d;

    logic                    w_active;
    logic                    w_wr;
    logic                    w_first;
    logic                    w_commit;
    logic                    w_shut;
    logic                    w_fcs_rise;
    logic [6:0]              w_index;
    logic [7:0]              w_product;
    logic [3:0]              w_size;
    logic [3:0]              w_rd_nibble;
    logic [3:0]              w_size_tab [4];

    assign w_active   = (z3_state == c_Z3_DATA) && autoconfig_cycle && !r_all_done;
    assign w_wr       = w_active && !READ;
    assign w_first    = w_wr && !r_fired;
    assign w_commit   = w_first && (ADDRL[5:0] == 6'h11);
    assign w_shut     = w_first && (ADDRL[5:0] == 6'h13);
    assign w_fcs_rise = FCS_n && !r_fcs_d;
    assign w_index    = {ADDRL[5:0], ADDRL[6]};
    assign w_product  = PROD_ID + {6'd0, r_cur_board};

    // Unused table slots are tied off so cur_board can index without a range check
    for (genvar gi = 0; gi < 4; gi++) begin : g_size
        if (gi < NUM_BOARDS) begin : g_used
            assign w_size_tab[gi] = BOARD_SIZE[4*gi +: 4];
        end else begin : g_unused
            assign w_size_tab[gi] = 4'h0;
        end
    end
    assign w_size = w_size_tab[r_cur_board];

    always_comb begin
        w_rd_nibble = 4'hF;
        case (w_index)
            7'h00: w_rd_nibble = ZORRO3 ? 4'b1010 : 4'b1110;
            7'h01: w_rd_nibble = w_size;
            7'h02: w_rd_nibble = ~w_product[7:4];
            7'h03: w_rd_nibble = ~w_product[3:0];
            7'h04: w_rd_nibble = ZORRO3 ? ~4'b1011 : ~4'b0000;
            7'h05: w_rd_nibble = ~4'b0001;
            7'h08: w_rd_nibble = ~MFG_ID[15:12];
            7'h09: w_rd_nibble = ~MFG_ID[11:8];
            7'h0A: w_rd_nibble = ~MFG_ID[7:4];
            7'h0B: w_rd_nibble = ~MFG_ID[3:0];
            7'h0C: w_rd_nibble = ~SERIAL[31:28];
            7'h0D: w_rd_nibble = ~SERIAL[27:24];
            7'h0E: w_rd_nibble = ~SERIAL[23:20];
            7'h0F: w_rd_nibble = ~SERIAL[19:16];
            7'h10: w_rd_nibble = ~SERIAL[15:12];
            7'h11: w_rd_nibble = ~SERIAL[11:8];
            7'h12: w_rd_nibble = ~SERIAL[7:4];
            7'h13: w_rd_nibble = ~SERIAL[3:0];
            7'h20: w_rd_nibble = 4'h0;
            7'h21: w_rd_nibble = 4'h0;
            default: w_rd_nibble = 4'hF;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            r_dout       <= 4'h0;
            r_dtack      <= 1'b0;
            r_cfgout_n   <= 1'b1;
            r_cur_board  <= 2'd0;
            r_all_done   <= 1'b0;
            r_configured <= '0;
            r_shutup     <= '0;
            r_base_addr  <= '0;
            r_pending    <= 4'h0;
            r_fired      <= 1'b0;
            r_fcs_d      <= 1'b1;
        end else begin
            r_fcs_d <= FCS_n;
            r_dtack <= w_active;

            // The next slot is released only once the completing bus cycle has ended
            if (w_fcs_rise) begin
                r_cfgout_n <= !r_all_done;
            end

            if (w_active && READ) begin
                r_dout <= w_rd_nibble;
            end

            if (FCS_n) begin
                r_fired <= 1'b0;
            end else if (w_active) begin
                r_fired <= 1'b1;
            end

            if (w_wr && (ADDRL[5:0] == 6'h12)) begin
                r_pending <= DIN;
            end

            if (w_commit || w_shut) begin
                for (int i = 0; i < NUM_BOARDS; i++) begin
                    if (r_cur_board == 2'(i)) begin
                        if (w_commit) begin
                            r_base_addr[8*i +: 8] <= {DIN, r_pending};
                            r_configured[i]       <= 1'b1;
                        end else begin
                            r_shutup[i] <= 1'b1;
                        end
                    end
                end
                if (r_cur_board == c_LAST_BOARD) begin
                    r_all_done <= 1'b1;
                end else begin
                    r_cur_board <= r_cur_board + 2'd1;
                    r_pending   <= 4'h0;
                end
            end
        end
    end

    assign DOUT       = r_dout;
    assign dtack      = r_dtack;
    assign CFGOUT_n   = r_cfgout_n;
    assign cur_board  = r_cur_board;
    assign all_done   = r_all_done;
    assign configured = r_configured;
    assign shutup     = r_shutup;
    assign base_addr  = r_base_addr;

endmodule
`default_nettype wire

// File: tb/tb_autoconfig_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_autoconfig_multi
// Brief    : Two autoconfig_multi variants driven in lockstep against a board-level model.
// Revision : 1.0
// ============================================================================
module tb_autoconfig_multi;

    logic       CLK = 1'b0;
    logic       RESET_n = 1'b0;
    logic       FCS_n = 1'b1;
    logic       autoconfig_cycle = 1'b0;
    logic [1:0] z3_state = 2'b00;
    logic [6:0] ADDRL = 7'h00;
    logic       READ = 1'b1;
    logic [3:0] DIN = 4'h0;

    logic [3:0]  DOUT0, DOUT1;
    logic        dtack0, dtack1, CFGOUT_n0, CFGOUT_n1, all_done0, all_done1;
    logic [1:0]  cur_board0, cur_board1;
    logic [1:0]  configured0, shutup0;
    logic [0:0]  configured1, shutup1;
    logic [15:0] base_addr0;
    logic [7:0]  base_addr1;

    autoconfig_multi #(
        .NUM_BOARDS(2), .ZORRO3(1'b1), .MFG_ID(16'd5194), .PROD_ID(8'h03),
        .SERIAL(32'h1234_ABCD), .BOARD_SIZE({4'h6, 4'h4})
    ) dut0 (
        .CLK(CLK), .RESET_n(RESET_n), .FCS_n(FCS_n), .autoconfig_cycle(autoconfig_cycle),
        .z3_state(z3_state), .ADDRL(ADDRL), .READ(READ), .DIN(DIN),
        .DOUT(DOUT0), .dtack(dtack0), .CFGOUT_n(CFGOUT_n0), .cur_board(cur_board0),
        .all_done(all_done0), .configured(configured0), .shutup(shutup0), .base_addr(base_addr0)
    );

    autoconfig_multi #(
        .NUM_BOARDS(1), .ZORRO3(1'b0), .MFG_ID(16'hBEEF), .PROD_ID(8'h7A),
        .SERIAL(32'h8765_4321), .BOARD_SIZE(4'h2)
    ) dut1 (
        .CLK(CLK), .RESET_n(RESET_n), .FCS_n(FCS_n), .autoconfig_cycle(autoconfig_cycle),
        .z3_state(z3_state), .ADDRL(ADDRL), .READ(READ), .DIN(DIN),
        .DOUT(DOUT1), .dtack(dtack1), .CFGOUT_n(CFGOUT_n1), .cur_board(cur_board1),
        .all_done(all_done1), .configured(configured1), .shutup(shutup1), .base_addr(base_addr1)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: one entry per DUT ----------------
    int          nbs   [2] = '{2, 1};
    bit          z3s   [2] = '{1'b1, 1'b0};
    logic [15:0] mfgs  [2] = '{16'd5194, 16'hBEEF};
    logic [7:0]  prods [2] = '{8'h03, 8'h7A};
    logic [31:0] sers  [2] = '{32'h1234_ABCD, 32'h8765_4321};
    logic [3:0]  sizes [2][4] = '{'{4'h4, 4'h6, 4'h0, 4'h0}, '{4'h2, 4'h0, 4'h0, 4'h0}};

    int          m_cur   [2];
    bit          m_done  [2];
    bit          m_conf  [2][4];
    bit          m_shut  [2][4];
    logic [7:0]  m_base  [2][4];
    logic [3:0]  m_pend  [2];
    bit          m_fired [2];
    logic [3:0]  m_dout  [2];
    bit          m_dtack [2];
    bit          m_cfgn  [2];
    bit          m_fcs_prev;

    function automatic logic [3:0] read_nib(input int k, input logic [6:0] idx, input int b);
        logic [7:0]  prod;
        logic [31:0] t;
        int          ix;
        prod = prods[k] + 8'(b);
        ix   = int'(idx);
        if (ix == 0)                  return z3s[k] ? 4'hA : 4'hE;
        if (ix == 1)                  return sizes[k][b];
        if (ix == 2)                  return ~prod[7:4];
        if (ix == 3)                  return ~prod[3:0];
        if (ix == 4)                  return z3s[k] ? 4'h4 : 4'hF;
        if (ix == 5)                  return 4'hE;
        if (ix >= 8 && ix <= 11) begin
            t = {16'd0, mfgs[k]} >> (4 * (11 - ix));
            return ~t[3:0];
        end
        if (ix >= 12 && ix <= 19) begin
            t = sers[k] >> (4 * (19 - ix));
            return ~t[3:0];
        end
        if (ix == 32 || ix == 33)     return 4'h0;
        return 4'hF;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_cur[k] = 0; m_done[k] = 0; m_pend[k] = 0; m_fired[k] = 0;
            m_dout[k] = 0; m_dtack[k] = 0; m_cfgn[k] = 1;
            for (int b = 0; b < 4; b++) begin
                m_conf[k][b] = 0; m_shut[k][b] = 0; m_base[k][b] = 8'h00;
            end
        end
        m_fcs_prev = 1'b1;
    endtask

    task automatic advance(input int k);
        if (m_cur[k] == nbs[k] - 1) m_done[k] = 1;
        else begin
            m_cur[k]++;
            m_pend[k] = 4'h0;
        end
    endtask

    task automatic model_clock();
        bit active, first, rise;
        rise = FCS_n && !m_fcs_prev;
        for (int k = 0; k < 2; k++) begin
            active = (z3_state == 2'b11) && autoconfig_cycle && !m_done[k];
            first  = active && !m_fired[k];
            if (rise) m_cfgn[k] = !m_done[k];
            m_dtack[k] = active;
            if (active && READ) m_dout[k] = read_nib(k, {ADDRL[5:0], ADDRL[6]}, m_cur[k]);
            if (FCS_n) m_fired[k] = 0;
            else if (active) m_fired[k] = 1;
            if (active && !READ) begin
                if (ADDRL[5:0] == 6'h12) m_pend[k] = DIN;
                else if (first && ADDRL[5:0] == 6'h11) begin
                    m_base[k][m_cur[k]] = {DIN, m_pend[k]};
                    m_conf[k][m_cur[k]] = 1;
                    advance(k);
                end else if (first && ADDRL[5:0] == 6'h13) begin
                    m_shut[k][m_cur[k]] = 1;
                    advance(k);
                end
            end
        end
        m_fcs_prev = FCS_n;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge CLK or negedge RESET_n);
            if (!RESET_n) model_reset();
            else model_clock();
        end
    end

    // ---------------- compare process ----------------
    initial begin
        forever begin
            @(negedge CLK);
            if (chk_en) begin
                chk("dout0",  DOUT0, m_dout[0]);
                chk("dtack0", dtack0, m_dtack[0]);
                chk("cfgout0", CFGOUT_n0, m_cfgn[0]);
                chk("cur0",   cur_board0, m_cur[0]);
                chk("done0",  all_done0, m_done[0]);
                chk("conf0",  configured0, {m_conf[0][1], m_conf[0][0]});
                chk("shut0",  shutup0, {m_shut[0][1], m_shut[0][0]});
                chk("base0",  base_addr0, {m_base[0][1], m_base[0][0]});
                chk("dout1",  DOUT1, m_dout[1]);
                chk("dtack1", dtack1, m_dtack[1]);
                chk("cfgout1", CFGOUT_n1, m_cfgn[1]);
                chk("cur1",   cur_board1, m_cur[1]);
                chk("done1",  all_done1, m_done[1]);
                chk("conf1",  configured1, m_conf[1][0]);
                chk("shut1",  shutup1, m_shut[1][0]);
                chk("base1",  base_addr1, m_base[1][0]);
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [3:0] cap_dout0, cap_dout1;
    logic       cap_dt0, cap_dt1, cap_cfg0;

    task automatic bus(input bit rd, input logic [6:0] a, input logic [3:0] d, input int n);
        @(negedge CLK);
        FCS_n = 1'b0; z3_state = 2'b11; autoconfig_cycle = 1'b1;
        READ = rd; ADDRL = a; DIN = d;
        repeat (n) @(negedge CLK);
        cap_dout0 = DOUT0; cap_dt0 = dtack0; cap_dout1 = DOUT1; cap_dt1 = dtack1;
        cap_cfg0 = CFGOUT_n0;
        FCS_n = 1'b1; z3_state = 2'b00; autoconfig_cycle = 1'b0;
        @(negedge CLK);
    endtask

    task automatic rd_idx(input logic [6:0] idx);
        bus(1'b1, {idx[0], idx[6:1]}, 4'h0, 1);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RESET_n = 1'b0; FCS_n = 1'b1; z3_state = 2'b00; autoconfig_cycle = 1'b0;
        @(negedge CLK);
        RESET_n = 1'b1;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_dout"}, DOUT0, 4'h0);
        chk({tag, "_dtack"}, dtack0, 1'b0);
        chk({tag, "_cur"}, cur_board0, 2'd0);
        chk({tag, "_done"}, all_done0, 1'b0);
        chk({tag, "_conf"}, configured0, 2'b00);
        chk({tag, "_shut"}, shutup0, 2'b00);
        chk({tag, "_base"}, base_addr0, 16'h0000);
        chk({tag, "_cfgout"}, CFGOUT_n0, 1'b1);
    endtask

    initial begin
        repeat (2) @(negedge CLK);
        chk_en = 1'b1;
        check_reset_state("rst");
        RESET_n = 1'b1;

        // ID reads on board 0
        rd_idx(7'h00); chk("rd00", cap_dout0, 4'hA); chk("rd00_dt", cap_dt0, 1'b1);
                       chk("z2_rd00", cap_dout1, 4'hE);
        rd_idx(7'h01); chk("rd01", cap_dout0, 4'h4); chk("z2_rd01", cap_dout1, 4'h2);
        rd_idx(7'h03); chk("rd03", cap_dout0, 4'hC);
        rd_idx(7'h04); chk("rd04", cap_dout0, 4'h4); chk("z2_rd04", cap_dout1, 4'hF);
        rd_idx(7'h08); chk("rd08", cap_dout0, 4'hE);
        rd_idx(7'h0C); chk("rd0C", cap_dout0, 4'hE);
        rd_idx(7'h21); chk("rd21", cap_dout0, 4'h0);
        rd_idx(7'h30); chk("rd30", cap_dout0, 4'hF); chk("rd30_dt", cap_dt0, 1'b1);

        // Base commit, write held for five clocks
        bus(1'b0, 7'h12, 4'h5, 1);
        bus(1'b0, 7'h11, 4'h4, 5);
        chk("commit_base", base_addr0, 16'h0045);
        chk("commit_conf", configured0, 2'b01);
        chk("commit_cur", cur_board0, 2'd1);
        chk("commit_done", all_done0, 1'b0);
        chk("commit_cfgout", CFGOUT_n0, 1'b1);
        chk("z2_base", base_addr1, 8'h45);
        chk("z2_done", all_done1, 1'b1);
        chk("z2_cfgout", CFGOUT_n1, 1'b0);
        rd_idx(7'h03); chk("rd03_b1", cap_dout0, 4'hB); chk("z2_noack", cap_dt1, 1'b0);
        rd_idx(7'h01); chk("rd01_b1", cap_dout0, 4'h6);

        // Shut up the last board
        bus(1'b0, 7'h13, 4'h9, 2);
        chk("shut_cfg_before", cap_cfg0, 1'b1);
        chk("shut_cfg_after", CFGOUT_n0, 1'b0);
        chk("shut_vec", shutup0, 2'b10);
        chk("shut_done", all_done0, 1'b1);
        chk("shut_base", base_addr0, 16'h0045);
        rd_idx(7'h00); chk("after_done_dt", cap_dt0, 1'b0);

        // Reset in the middle of a sequence
        do_reset();
        bus(1'b0, 7'h12, 4'h3, 1);
        bus(1'b0, 7'h11, 4'hC, 1);
        chk("pre_rst_base", base_addr0, 16'h00C3);
        do_reset();
        check_reset_state("midrst");
        bus(1'b0, 7'h12, 4'h7, 1);
        bus(1'b0, 7'h11, 4'hA, 2);
        chk("recfg_base", base_addr0, 16'h00A7);
        chk("recfg_conf", configured0, 2'b01);

        // Randomised bus traffic
        for (int c = 0; c < 400; c++) begin
            int sel;
            if ($urandom_range(0, 39) == 0) do_reset();
            @(negedge CLK);
            sel = int'($urandom_range(0, 5));
            FCS_n = 1'b0;
            z3_state = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
            autoconfig_cycle = ($urandom_range(0, 7) != 0);
            READ = 1'($urandom_range(0, 1));
            DIN = 4'($urandom_range(0, 15));
            case (sel)
                0: ADDRL = {1'($urandom_range(0, 1)), 6'h12};
                1: ADDRL = {1'($urandom_range(0, 1)), 6'h11};
                2: ADDRL = {1'($urandom_range(0, 1)), 6'h13};
                default: ADDRL = 7'($urandom_range(0, 127));
            endcase
            if (sel <= 2 && $urandom_range(0, 3) != 0) READ = 1'b0;
            repeat ($urandom_range(1, 4)) @(negedge CLK);
            FCS_n = 1'b1;
            z3_state = 2'($urandom_range(0, 2));
            autoconfig_cycle = 1'($urandom_range(0, 1));
            ADDRL = 7'($urandom_range(0, 127));
            READ = 1'($urandom_range(0, 1));
            repeat ($urandom_range(0, 1)) @(negedge CLK);
        end

        @(negedge CLK);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
